// File: rtl/cwc_capture_reader.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------------+
// | Module : cwc_capture_reader                                                 |
// | Brief  : Streams capture-RAM samples, oldest first, as OUT_W-bit chunks.    |
// | Rev    : 1.0                                                                |
// +-----------------------------------------------------------------------------+
module cwc_capture_reader #(
  parameter int RAM_LEN        = 793,
  parameter int RAM_DATA_DEPTH = 4096,
  parameter int ADDR_W         = 12,
  parameter int OUT_W          = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [ADDR_W-1:0]   start_addr_i,
  input  logic [ADDR_W:0]     num_samples_i,
  output logic                ram_rd_en_o,
  output logic [ADDR_W-1:0]   ram_rd_addr_o,
  input  logic [RAM_LEN-1:0]  ram_rd_data_i,
  output logic [OUT_W-1:0]    dout_o,
  output logic                dout_valid_o,
  input  logic                dout_ready_i,
  output logic                dout_last_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int CHUNKS  = (RAM_LEN + OUT_W - 1) / OUT_W;
  localparam int CHUNK_W = $clog2(CHUNKS + 1);
  localparam int BUF_W   = CHUNKS * OUT_W;
  localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(CHUNKS - 1);
  localparam logic [ADDR_W:0]    DEPTH      = (ADDR_W + 1)'(RAM_DATA_DEPTH);
  localparam logic [ADDR_W:0]    ONE        = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     left_q, left_d;
  logic [CHUNK_W-1:0]  chunk_q, chunk_d;
  logic [BUF_W-1:0]    buf_q;
  logic [BUF_W-1:0]    w_fill;
  logic [ADDR_W:0]     w_count;
  logic                w_rd_en;
  logic [ADDR_W-1:0]   w_rd_addr;

  assign w_count = (num_samples_i > DEPTH) ? DEPTH : num_samples_i;

  // Pad the sample to a whole number of chunks; the tail bits read as zero.
  always_comb begin
    w_fill                = '0;
    w_fill[RAM_LEN-1:0]   = ram_rd_data_i;
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    left_d    = left_q;
    chunk_d   = chunk_q;
    w_rd_en   = 1'b0;
    w_rd_addr = '0;
    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          addr_d = start_addr_i;
          left_d = w_count;
          if (w_count == '0) begin
            state_d = S_DONE;
          end else begin
            w_rd_en   = 1'b1;
            w_rd_addr = start_addr_i;
            state_d   = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        chunk_d = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (dout_ready_i) begin
          if (chunk_q == LAST_CHUNK) begin
            chunk_d = '0;
            left_d  = left_q - 1'b1;
            addr_d  = addr_q + 1'b1;
            // Next read overlaps the final handshake to keep the gap at two cycles.
            if (left_q > ONE) begin
              w_rd_en   = !abort_i;
              w_rd_addr = addr_q + 1'b1;
              state_d   = S_WAIT;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            chunk_d = chunk_q + 1'b1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      left_q  <= '0;
      chunk_q <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      left_q  <= left_d;
      chunk_q <= chunk_d;
      if (state_q == S_WAIT) begin
        buf_q <= w_fill;
      end
    end
  end

  assign ram_rd_en_o   = w_rd_en && !rst;
  assign ram_rd_addr_o = rst ? '0 : w_rd_addr;
  assign dout_valid_o  = (state_q == S_SEND);
  assign dout_o        = (state_q == S_SEND) ? buf_q[int'(chunk_q) * OUT_W +: OUT_W] : '0;
  assign dout_last_o   = (state_q == S_SEND) && (chunk_q == LAST_CHUNK) && (left_q == ONE);
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_cwc_capture_reader.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------------+
// | Module : tb_cwc_capture_reader                                              |
// | Brief  : Directed self-checking bench for the capture readout engine.       |
// | Rev    : 1.0                                                                |
// +-----------------------------------------------------------------------------+
module tb_cwc_capture_reader;

  localparam int RAM_LEN = 793;
  localparam int CHUNKS  = 25;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [11:0]        start_addr = '0;
  logic [12:0]        num_samples = '0;
  logic               ram_rd_en;
  logic [11:0]        ram_rd_addr;
  logic [RAM_LEN-1:0] ram_rd_data = '0;
  logic [31:0]        dout;
  logic               dout_valid;
  logic               dout_ready = 1'b1;
  logic               dout_last;
  logic               busy;
  logic               done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic bp_en = 1'b0;
  int   bp_ph = 0;

  logic [11:0] mon_base;
  int mon_total, mon_sample, mon_chunk, mon_chunks, mon_first;
  int mon_last_cycle, mon_last_idx, mon_last_count, mon_done, mon_done_cycle;
  logic [11:0] reads[$];
  logic        prev_stall, prev_last;
  logic [31:0] prev_dout;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cwc_capture_reader dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start),
    .abort_i       (abort),
    .start_addr_i  (start_addr),
    .num_samples_i (num_samples),
    .ram_rd_en_o   (ram_rd_en),
    .ram_rd_addr_o (ram_rd_addr),
    .ram_rd_data_i (ram_rd_data),
    .dout_o        (dout),
    .dout_valid_o  (dout_valid),
    .dout_ready_i  (dout_ready),
    .dout_last_o   (dout_last),
    .busy_o        (busy),
    .done_o        (done)
  );

  function automatic logic [31:0] word_of(input logic [11:0] a, input int k);
    return {4'h5, a, 3'b000, 5'(k), 8'h3C};
  endfunction

  function automatic logic [RAM_LEN-1:0] sample_of(input logic [11:0] a);
    logic [RAM_LEN-1:0] s;
    logic [31:0] w;
    s = '0;
    for (int k = 0; k < CHUNKS; k++) begin
      w = word_of(a, k);
      for (int b = 0; b < 32; b++)
        if (k * 32 + b < RAM_LEN) s[k*32+b] = (a == 12'd5) ? 1'(b % 2) : w[b];
    end
    return s;
  endfunction

  function automatic logic [31:0] exp_chunk(input logic [11:0] a, input int k);
    if (a == 12'd5) return (k == 24) ? 32'h00AA_AAAA : 32'hAAAA_AAAA;
    if (k == 24) return word_of(a, k) & 32'h01FF_FFFF;
    return word_of(a, k);
  endfunction

  always @(posedge clk) if (ram_rd_en) ram_rd_data <= sample_of(ram_rd_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic mon_clear(input logic [11:0] base, input int total);
    mon_base = base; mon_total = total; mon_sample = 0; mon_chunk = 0; mon_chunks = 0;
    mon_first = -1; mon_last_cycle = -1; mon_last_idx = -1; mon_last_count = 0;
    mon_done = 0; mon_done_cycle = -1; prev_stall = 1'b0; prev_last = 1'b0; prev_dout = '0;
    reads.delete();
  endtask

  // Stream monitor: samples at the falling edge, between the driver and the DUT edge.
  initial begin
    mon_clear(12'd0, 0);
    forever begin
      @(negedge clk);
      if (ram_rd_en) reads.push_back(ram_rd_addr);
      if (done) begin mon_done++; mon_done_cycle = cyc; end
      if (dout_valid && mon_first < 0) mon_first = cyc;
      if (dout_last && !dout_valid) check("last_without_valid", 32'(dout_last), 32'd0);
      if (prev_stall) begin
        check("stall_valid", 32'(dout_valid), 32'd1);
        check("stall_dout", dout, prev_dout);
        check("stall_last", 32'(dout_last), 32'(prev_last));
      end
      if (dout_valid && dout_ready) begin
        check("dout", dout, exp_chunk(12'(int'(mon_base) + mon_sample), mon_chunk));
        check("dout_last", 32'(dout_last),
              32'((mon_chunk == CHUNKS - 1) && (mon_sample == mon_total - 1)));
        if (dout_last) begin
          mon_last_idx = mon_chunks; mon_last_cycle = cyc; mon_last_count++;
        end
        mon_chunks++;
        if (mon_chunk == CHUNKS - 1) begin mon_chunk = 0; mon_sample++; end
        else mon_chunk++;
      end
      prev_stall = dout_valid && !dout_ready;
      prev_dout  = dout;
      prev_last  = dout_last;
    end
  end

  // Sink ready: pattern 1,0,0,1 under backpressure, otherwise always ready.
  initial forever begin
    @(posedge clk); #1;
    if (bp_en) begin
      dout_ready = (bp_ph == 0) || (bp_ph == 3);
      bp_ph = (bp_ph + 1) % 4;
    end else begin
      dout_ready = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic start_run(input logic [11:0] a, input logic [12:0] n,
                           output logic en0, output logic [11:0] addr0, output int c0);
    tick();
    mon_clear(a, int'(n));
    start = 1'b1; start_addr = a; num_samples = n;
    #1;
    en0 = ram_rd_en; addr0 = ram_rd_addr; c0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int idle_c);
    int k = 0;
    while (busy && k < budget) begin tick(); k++; end
    check("timeout_busy", 32'(busy), 32'd0);
    idle_c = cyc;
  endtask

  task automatic wait_pos(input int s, input int c, input int budget);
    int k = 0;
    while (!(mon_sample > s || (mon_sample == s && mon_chunk >= c)) && k < budget) begin
      tick(); k++;
    end
    check("timeout_progress", 32'(mon_sample > s || (mon_sample == s && mon_chunk >= c)), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(dout_valid), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_rd_en"}, 32'(ram_rd_en), 32'd0);
    check({tag, "_dout"},  dout, 32'd0);
    check({tag, "_last"},  32'(dout_last), 32'd0);
  endtask

  initial begin
    logic en0;
    logic [11:0] addr0;
    int c0, ic;

    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;

    // Single sample at address 5, alternating-bit pattern.
    start_run(12'd5, 13'd1, en0, addr0, c0);
    check("t1_rd_en", 32'(en0), 32'd1);
    check("t1_rd_addr", 32'(addr0), 32'd5);
    wait_idle(100, ic);
    check("t1_latency", 32'(mon_first - c0), 32'd2);
    check("t1_chunks", 32'(mon_chunks), 32'd25);
    check("t1_last_idx", 32'(mon_last_idx), 32'd24);
    check("t1_last_count", 32'(mon_last_count), 32'd1);
    check("t1_done_count", 32'(mon_done), 32'd1);
    check("t1_done_after_last", 32'(mon_done_cycle - mon_last_cycle), 32'd1);
    check("t1_busy_fall", 32'(ic - mon_done_cycle), 32'd1);
    check("t1_reads", 32'(reads.size()), 32'd1);

    // Wrap across the top of the buffer.
    start_run(12'd4094, 13'd3, en0, addr0, c0);
    wait_idle(300, ic);
    check("t2_reads", 32'(reads.size()), 32'd3);
    if (reads.size() == 3) begin
      check("t2_addr0", 32'(reads[0]), 32'd4094);
      check("t2_addr1", 32'(reads[1]), 32'd4095);
      check("t2_addr2", 32'(reads[2]), 32'd0);
    end
    check("t2_chunks", 32'(mon_chunks), 32'd75);
    check("t2_last_idx", 32'(mon_last_idx), 32'd74);
    check("t2_done_count", 32'(mon_done), 32'd1);

    // Backpressure pattern 1,0,0,1.
    bp_en = 1'b1; bp_ph = 0;
    start_run(12'd100, 13'd2, en0, addr0, c0);
    wait_idle(500, ic);
    bp_en = 1'b0;
    check("t3_chunks", 32'(mon_chunks), 32'd50);
    check("t3_samples", 32'(mon_sample), 32'd2);
    check("t3_last_idx", 32'(mon_last_idx), 32'd49);
    check("t3_done_count", 32'(mon_done), 32'd1);

    // Zero samples.
    start_run(12'd9, 13'd0, en0, addr0, c0);
    check("t4_rd_en", 32'(en0), 32'd0);
    wait_idle(10, ic);
    check("t4_no_valid", 32'(mon_first), 32'hFFFF_FFFF);
    check("t4_reads", 32'(reads.size()), 32'd0);
    check("t4_done_count", 32'(mon_done), 32'd1);
    check("t4_done_cycle", 32'(mon_done_cycle - c0), 32'd1);
    check("t4_idle_cycle", 32'(ic - c0), 32'd2);

    // Full-depth request: wraps, ignores a second start, then aborted.
    start_run(12'd4090, 13'd4096, en0, addr0, c0);
    wait_pos(8, 0, 1000);
    start = 1'b1; start_addr = 12'd7; num_samples = 13'd1;
    tick();
    start = 1'b0;
    wait_pos(11, 0, 1000);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_abort_busy", 32'(busy), 32'd0);
    check("t5_abort_valid", 32'(dout_valid), 32'd0);
    check("t5_reads", 32'(reads.size()), 32'd12);
    foreach (reads[i]) check("t5_read_addr", 32'(reads[i]), 32'((4090 + i) % 4096));
    check("t5_done_count", 32'(mon_done), 32'd0);
    check("t5_last_count", 32'(mon_last_count), 32'd0);

    // Abort with a handshake during chunk 11 of the second sample.
    start_run(12'd20, 13'd5, en0, addr0, c0);
    wait_pos(1, 11, 200);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_valid", 32'(dout_valid), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_chunks", 32'(mon_chunks), 32'd37);
    repeat (3) tick();
    check("t6_done_count", 32'(mon_done), 32'd0);

    // Abort and start together in IDLE: nothing starts.
    mon_clear(12'd0, 0);
    start = 1'b1; abort = 1'b1; start_addr = 12'd40; num_samples = 13'd1;
    #1;
    check("t7_rd_en", 32'(ram_rd_en), 32'd0);
    tick();
    start = 1'b0; abort = 1'b0;
    check("t7_busy", 32'(busy), 32'd0);

    // Reset in the middle of SEND.
    start_run(12'd30, 13'd2, en0, addr0, c0);
    repeat (5) tick();
    check("t8_in_send", 32'(dout_valid), 32'd1);
    rst = 1'b1;
    tick();
    check_all_zero("t8_rst");
    rst = 1'b0;
    repeat (3) tick();
    check("t8_done_count", 32'(mon_done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
